// File: rtl/systolic_result_writer_pkg.sv
// systolic_result_writer_pkg: shared widths, writer state enum and lane-mask helper
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef DIM_WIDTH
`define DIM_WIDTH 16
`endif
`ifndef BANDWIDTH
`define BANDWIDTH 8
`endif
package systolic_result_writer_pkg;
  localparam int TILE_N = `BANDWIDTH;
  localparam int WR_ROW_W = $clog2(TILE_N) + 1;
  typedef enum logic [1:0] {IDLE, WRITE, DONE} wr_state_t;
  function automatic logic [`BANDWIDTH-1:0] lane_mask(input logic [WR_ROW_W-1:0] cols);
    logic [`BANDWIDTH:0] m;
    m = ((`BANDWIDTH+1)'(1) << cols) - (`BANDWIDTH+1)'(1);
    return m[`BANDWIDTH-1:0];
  endfunction
endpackage

// File: rtl/systolic_result_writer_accum.sv
// systolic_result_writer_accum: loadable address accumulator (value = init, then += offset per en)
//   clock, reset : clock and sync active-high reset
//   load, init   : load init into value (priority over en)
//   en, offset   : add offset to value, wrapping modulo 2^ADDR_WIDTH
//   value        : current accumulated address
module systolic_result_writer_accum (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   load,
  input  logic                   en,
  input  logic [`ADDR_WIDTH-1:0] init,
  input  logic [`DIM_WIDTH-1:0]  offset,
  output logic [`ADDR_WIDTH-1:0] value
);
  always_ff @(posedge clock)
    if (reset) value <= '0;
    else if (load) value <= init;
    else if (en) value <= value + `ADDR_WIDTH'(offset);
endmodule

// File: rtl/systolic_result_writer.sv
// systolic_result_writer: writes a captured N x N result tile to memory one row per accepted beat
//   clock, reset            : clock and sync active-high reset
//   start                   : capture request, ignored while busy
//   base_C, dim_col_C       : destination row-0 address and row stride
//   valid_rows, valid_cols  : edge-tile extents, clamped to N
//   In                      : result tile, row r at In[r*N*DW +: N*DW], lane c within the row
//   writeready              : memory accepts the beat when write && writeready
//   write, write_addr, writedata, writemask : row write request
//   busy, done              : busy in WRITE/DONE, done pulses once in DONE
module systolic_result_writer
  import systolic_result_writer_pkg::*;
#(
  parameter int N = TILE_N
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              start,
  input  logic [`ADDR_WIDTH-1:0]            base_C,
  input  logic [`DIM_WIDTH-1:0]             dim_col_C,
  input  logic [WR_ROW_W-1:0]               valid_rows,
  input  logic [WR_ROW_W-1:0]               valid_cols,
  input  logic [N*N*`DATA_WIDTH-1:0]        In,
  input  logic                              writeready,
  output logic                              write,
  output logic [`ADDR_WIDTH-1:0]            write_addr,
  output logic [`BANDWIDTH*`DATA_WIDTH-1:0] writedata,
  output logic [`BANDWIDTH-1:0]             writemask,
  output logic                              busy,
  output logic                              done
);
  wr_state_t state, next;
  logic [N-1:0][N*`DATA_WIDTH-1:0] tile;
  logic [WR_ROW_W-1:0] rows, cols, row;
  logic [`DIM_WIDTH-1:0] dim;
  logic [`ADDR_WIDTH-1:0] addr;
  logic accept, beat;
  assign accept = state == IDLE && start;
  assign beat = write && writeready;
  systolic_result_writer_accum u_addr (
    .clock(clock), .reset(reset), .load(accept), .en(beat),
    .init(base_C), .offset(dim), .value(addr)
  );
  always_ff @(posedge clock)
    if (reset) begin
      state <= IDLE;
      tile <= '0;
      rows <= '0;
      cols <= '0;
      row <= '0;
      dim <= '0;
    end else begin
      state <= next;
      if (accept) begin
        tile <= In;
        rows <= valid_rows > WR_ROW_W'(N) ? WR_ROW_W'(N) : valid_rows;
        cols <= valid_cols > WR_ROW_W'(N) ? WR_ROW_W'(N) : valid_cols;
        dim <= dim_col_C;
        row <= '0;
      end else if (beat) row <= row + WR_ROW_W'(1);
    end
  always_comb begin
    next = state == IDLE  ? (start ? (valid_rows != '0 ? WRITE : DONE) : IDLE) :
           state == WRITE ? (writeready && row == rows - WR_ROW_W'(1) ? DONE : WRITE) :
                            IDLE;
    write = state == WRITE;
    busy = state != IDLE;
    done = state == DONE;
    write_addr = write ? addr : '0;
    writedata = write ? tile[row[WR_ROW_W-2:0]] : '0;
    writemask = write ? lane_mask(cols) : '0;
  end
endmodule

// File: tb/tb_systolic_result_writer.sv
// tb_systolic_result_writer: randomized bench checking the writer against a beat-queue model
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef DIM_WIDTH
`define DIM_WIDTH 16
`endif
`ifndef BANDWIDTH
`define BANDWIDTH 8
`endif
module tb_systolic_result_writer;
  localparam int N = 8;
  localparam int DW = `DATA_WIDTH;
  localparam int AW = `ADDR_WIDTH;
  localparam int RW = $clog2(N) + 1;
  logic clock = 0, reset = 1, start = 0, writeready = 1;
  logic [AW-1:0] base_C = 0;
  logic [`DIM_WIDTH-1:0] dim_col_C = 0;
  logic [RW-1:0] valid_rows = 0, valid_cols = 0;
  logic [N*N*DW-1:0] In = 0;
  logic write, busy, done;
  logic [AW-1:0] write_addr;
  logic [N*DW-1:0] writedata;
  logic [N-1:0] writemask;
  systolic_result_writer #(.N(N)) dut (
    .clock(clock), .reset(reset), .start(start), .base_C(base_C), .dim_col_C(dim_col_C),
    .valid_rows(valid_rows), .valid_cols(valid_cols), .In(In), .writeready(writeready),
    .write(write), .write_addr(write_addr), .writedata(writedata), .writemask(writemask),
    .busy(busy), .done(done)
  );
  always #5 clock = ~clock;
  typedef struct {logic [AW-1:0] a; logic [N*DW-1:0] d; logic [N-1:0] m;} beat_t;
  beat_t q[$];
  bit done_pend = 0, armed = 0;
  int total = 0, bad = 0, cyc = 0, start_cyc = 0, done_cyc = 0, rmode = 0;
  logic [AW-1:0] acc_a[$];
  logic [N-1:0] acc_m[$];
  logic [N*DW-1:0] acc_d[$];
  task automatic chk(input string nm, input logic [N*DW-1:0] act, input logic [N*DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  task automatic build();
    int rows, cols;
    beat_t b;
    rows = valid_rows > N ? N : int'(valid_rows);
    cols = valid_cols > N ? N : int'(valid_cols);
    for (int r = 0; r < rows; r++) begin
      b.a = AW'(32'(base_C) + r * 32'(dim_col_C));
      b.d = In[r*N*DW +: N*DW];
      b.m = N'((1 << cols) - 1);
      q.push_back(b);
    end
    if (rows == 0) done_pend = 1;
  endtask
  always @(negedge clock) begin
    bit idle_now;
    cyc++;
    idle_now = q.size() == 0 && !done_pend;
    if (armed) begin
      if (q.size() > 0) begin
        chk("write", write, 1);
        chk("addr", write_addr, q[0].a);
        chk("data", writedata, q[0].d);
        chk("mask", writemask, q[0].m);
        chk("busy_wr", busy, 1);
        chk("done_wr", done, 0);
        if (writeready) begin
          acc_a.push_back(write_addr);
          acc_m.push_back(writemask);
          acc_d.push_back(writedata);
          void'(q.pop_front());
          if (q.size() == 0) done_pend = 1;
        end
      end else if (done_pend) begin
        chk("done", done, 1);
        chk("busy_done", busy, 1);
        chk("write_done", write, 0);
        done_cyc = cyc;
        done_pend = 0;
      end else begin
        chk("idle_write", write, 0);
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
      end
      if (reset) begin
        q.delete();
        done_pend = 0;
      end else if (idle_now && start) begin
        build();
        start_cyc = cyc;
      end
    end
  end
  initial begin
    int k = 0;
    forever begin
      @(posedge clock);
      #1;
      writeready = rmode == 0 ? 1'b1 : rmode == 1 ? (k % 3 == 0) : 1'($urandom_range(0, 1));
      k++;
    end
  end
  task automatic scramble();
    for (int i = 0; i < N * N * DW / 32; i++) In[i*32 +: 32] = $urandom;
  endtask
  task automatic go(input logic [AW-1:0] b, input logic [`DIM_WIDTH-1:0] d,
                    input int vr, input int vc, input bit pattern);
    acc_a.delete();
    acc_m.delete();
    acc_d.delete();
    @(posedge clock);
    #1;
    base_C = b;
    dim_col_C = d;
    valid_rows = RW'(vr);
    valid_cols = RW'(vc);
    if (pattern) for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) In[(r*N+c)*DW +: DW] = DW'(r*8+c);
    else scramble();
    start = 1;
    @(posedge clock);
    #1;
    start = 0;
    scramble();
    base_C = AW'($urandom);
    dim_col_C = `DIM_WIDTH'($urandom);
  endtask
  task automatic finish_op();
    int i;
    for (i = 0; i < 400 && (q.size() != 0 || done_pend); i++) @(posedge clock);
    if (i == 400) chk("timeout", 0, 1);
  endtask
  initial begin
    logic [N*DW-1:0] row;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_write", write, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", write_addr, 0);
    chk("rst_data", writedata, 0);
    chk("rst_mask", writemask, 0);
    @(posedge clock);
    #1;
    reset = 0;
    armed = 1;
    rmode = 0;
    go(16'h100, 16, 8, 8, 1);
    finish_op();
    chk("full_n", acc_a.size(), 8);
    chk("full_a0", acc_a[0], 16'h100);
    chk("full_a7", acc_a[7], 16'h170);
    chk("full_m", acc_m[0], 8'hFF);
    row = acc_d[1];
    chk("full_d12", row[2*DW +: DW], 10);
    row = acc_d[7];
    chk("full_d77", row[7*DW +: DW], 63);
    chk("full_lat", done_cyc - start_cyc, 9);
    rmode = 1;
    go(16'h100, 16, 8, 8, 1);
    finish_op();
    chk("bp_n", acc_a.size(), 8);
    chk("bp_a7", acc_a[7], 16'h170);
    rmode = 0;
    go(16'h20, 10, 3, 5, 0);
    finish_op();
    chk("edge_n", acc_a.size(), 3);
    chk("edge_a1", acc_a[1], 16'h2A);
    chk("edge_a2", acc_a[2], 16'h34);
    chk("edge_m", acc_m[0], 8'h1F);
    chk("edge_lat", done_cyc - start_cyc, 4);
    go(16'h40, 4, 0, 8, 0);
    finish_op();
    chk("zero_n", acc_a.size(), 0);
    chk("zero_lat", done_cyc - start_cyc, 1);
    go(16'h200, 16, 8, 8, 0);
    for (int i = 0; i < 100 && acc_a.size() < 4; i++) @(posedge clock);
    #1;
    reset = 1;
    @(negedge clock);
    @(negedge clock);
    chk("mid_write", write, 0);
    chk("mid_busy", busy, 0);
    @(posedge clock);
    #1;
    reset = 0;
    rmode = 2;
    go(16'h300, 32, 8, 8, 0);
    finish_op();
    chk("fresh_n", acc_a.size(), 8);
    chk("fresh_a0", acc_a[0], 16'h300);
    go(16'h400, 16, 8, 8, 0);
    repeat (2) @(posedge clock);
    #1;
    base_C = 16'h500;
    start = 1;
    @(posedge clock);
    #1;
    start = 0;
    finish_op();
    chk("busy_n", acc_a.size(), 8);
    chk("busy_a7", acc_a[7], 16'h470);
    rmode = 0;
    go(16'hFFF0, 16, 3, 8, 0);
    finish_op();
    chk("wrap_a1", acc_a[1], 0);
    go(16'h10, 2, 12, 9, 0);
    finish_op();
    chk("clamp_n", acc_a.size(), 8);
    chk("clamp_m", acc_m[0], 8'hFF);
    rmode = 2;
    for (int t = 0; t < 25; t++) begin
      go(AW'($urandom), `DIM_WIDTH'($urandom), $urandom_range(0, 15), $urandom_range(0, 15), 0);
      finish_op();
      repeat ($urandom_range(0, 2)) @(posedge clock);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
